plc_fetch_unit: RTL and testbench
=================================

Name: plc_fetch_unit

Overview:
- Instruction fetch stage directly downstream of the program word memory.
- Drives the memory address combinationally from its program counter and captures the 24-bit instruction word.
- Splits the word into opcode and operand and hands it to the IL decoder over a valid/ready handshake.
- Manages the PLC scan cycle: end-of-program detection, scan restart, scan-time measurement and a scan watchdog.

Parameters:
- IA_W, 16, program address width.
- ID_W, 24, instruction word width.
- OP_W, 8, opcode width; opcode = word[ID_W-1:ID_W-OP_W], operand = word[ID_W-OP_W-1:0].
- RESET_PC, 0, scan start address.
- WDT_LIMIT, 16'hFFFF, maximum cycles per scan before fault.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- RUN  in  1  scan enable from the mode controller.
- IM_A  out  IA_W  program memory address; equals PC, combinational from the PC register.
- IM_DQ  in  ID_W  program memory read data; asynchronous read of IM_A.
- IR_VALID  out  1  instruction register holds an unconsumed word.
- IR_READY  in  1  decoder accepts the word.
- IR_OP  out  OP_W  opcode.
- IR_ARG  out  ID_W-OP_W  operand.
- IR_PC  out  IA_W  address the word was fetched from.
- BR_TAKE  in  1  execute-stage redirect request.
- BR_TGT  in  IA_W  redirect target.
- SCAN_END  out  1  one-cycle pulse at end of scan.
- SCAN_TIME  out  16  cycle count of the last completed scan.
- WDT_FAULT  out  1  sticky watchdog fault.
- STATE  out  2  00 IDLE, 01 FETCH, 10 FAULT.

Behaviour:
- Reset (async, nRST=0): PC=RESET_PC, STATE=IDLE, IR_VALID=0, IR_OP=0, IR_ARG=0, IR_PC=0, SCAN_END=0, SCAN_TIME=0, WDT_FAULT=0, scan counter=0.
- IDLE: no fetch, IR_VALID=0. Moves to FETCH the cycle after RUN=1 is sampled; PC is RESET_PC on entry.
- FETCH, load condition: load = (!IR_VALID || IR_READY) && !BR_TAKE.
- FETCH, normal load: on load, IR <= IM_DQ, IR_PC <= PC, IR_VALID <= 1, PC <= PC+1. PC wraps from all-ones to 0.
- FETCH, stall: if IR_VALID && !IR_READY, PC and IR hold.
- FETCH, consume with no load: if IR_READY is high and no new word is loaded, IR_VALID <= 0.
- Latency: memory word at PC appears on IR_* one cycle after the load edge.
- Redirect: BR_TAKE has highest priority in FETCH. PC <= BR_TGT, IR_VALID <= 0 (flush), no word loaded that cycle. The first word from BR_TGT is valid two edges after the BR_TAKE edge.
- End of scan: IM_DQ opcode == `IA_JMP with operand 16'hFFFF, sampled when load would occur. The word is not issued to IR.
  - PC <= RESET_PC.
  - SCAN_END pulses for one cycle.
  - SCAN_TIME <= counter+1; counter <= 0.
  - If RUN=0 at that edge, go to IDLE; otherwise continue in FETCH.
  - A JMP with any other operand is issued normally.
- RUN deasserted mid-scan: the scan completes; the transition to IDLE happens only at the end-of-scan word.
- Scan counter: increments every FETCH cycle, including stalls, and saturates at 16'hFFFF.
- Watchdog: when the counter reaches WDT_LIMIT in FETCH, go to FAULT, set WDT_FAULT=1 and IR_VALID=0. FAULT is exited only by nRST.
- Simultaneous events: BR_TAKE beats end-of-scan detection and the watchdog beats BR_TAKE.
- IR_VALID never drops while IR_READY=0 unless a flush or fault occurs.

Test Plan:
- Reset then RUN=1, IR_READY=1, memory 0:{LDI,0001}, 1:{ADD,0001}, 2:{JMP,FFFF} -> IR_PC 0 then 1 on consecutive cycles; SCAN_END pulses; SCAN_TIME=3; IR_PC=0 reissued.
- Hold IR_READY=0 for 4 cycles at PC=1 -> IR_PC=0 and PC=1 are stable; on release, word 1 follows next cycle with no word dropped or duplicated.
- BR_TAKE=1, BR_TGT=16'h0010 while a word is valid -> IR_VALID=0 next cycle, then IR_PC=16'h0010.
- Drop RUN at PC=1 -> word 1 issues, then at the JMP FFFF: SCAN_END=1, STATE=IDLE, IR_VALID=0.
- WDT_LIMIT=8 with a JMP 0000 loop -> WDT_FAULT=1 and STATE=FAULT at counter 8; fault held until nRST=0.
- Assert nRST=0 mid-stall -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/plc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : plc_fetch_unit
// Brief    : PLC instruction fetch stage. Drives the program memory address
//            from the PC, registers the returned word into an instruction
//            register handed to the IL decoder over valid/ready, and runs the
//            scan cycle (end-of-scan restart, scan-time measurement and a
//            sticky scan watchdog).
// Revision : 1.0 - initial release
// ============================================================================

// Opcode of the IL jump instruction; a jump to operand all-ones marks the
// end of the program and triggers a scan restart.
`ifndef IA_JMP
`define IA_JMP 8'h30
`endif

module plc_fetch_unit #(
   parameter int              IA_W      = 16,
   parameter int              ID_W      = 24,
   parameter int              OP_W      = 8,
   parameter logic [IA_W-1:0] RESET_PC  = '0,
   parameter logic [15:0]     WDT_LIMIT = 16'hFFFF
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 RUN,
   output logic [IA_W-1:0]      IM_A,
   input  logic [ID_W-1:0]      IM_DQ,
   output logic                 IR_VALID,
   input  logic                 IR_READY,
   output logic [OP_W-1:0]      IR_OP,
   output logic [ID_W-OP_W-1:0] IR_ARG,
   output logic [IA_W-1:0]      IR_PC,
   input  logic                 BR_TAKE,
   input  logic [IA_W-1:0]      BR_TGT,
   output logic                 SCAN_END,
   output logic [15:0]          SCAN_TIME,
   output logic                 WDT_FAULT,
   output logic [1:0]           STATE
);

   localparam int ARG_W = ID_W - OP_W;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_FETCH = 2'b01;
   localparam logic [1:0] S_FAULT = 2'b10;

   logic [1:0]      state;
   logic [IA_W-1:0] pc;
   logic [15:0]     scan_cnt;

   logic [OP_W-1:0]  im_op;
   logic [ARG_W-1:0] im_arg;
   logic             eos_word;
   logic             in_fetch;
   logic             wdt_hit;
   logic             redirect;
   logic             load;
   logic             scan_done;
   logic             issue;
   logic [15:0]      cnt_inc;

   assign im_op  = IM_DQ[ID_W-1 -: OP_W];
   assign im_arg = IM_DQ[ARG_W-1:0];

   // End-of-program marker: JMP with an all-ones operand
   assign eos_word = (im_op == OP_W'(`IA_JMP)) && (im_arg == {ARG_W{1'b1}});

   // Event priority inside FETCH: watchdog, then redirect, then load
   assign in_fetch  = (state == S_FETCH);
   assign wdt_hit   = in_fetch && (scan_cnt == WDT_LIMIT);
   assign redirect  = in_fetch && !wdt_hit && BR_TAKE;
   assign load      = in_fetch && !wdt_hit && !BR_TAKE && (!IR_VALID || IR_READY);
   assign scan_done = load && eos_word;
   assign issue     = load && !eos_word;

   // Scan counter saturates rather than wrapping
   assign cnt_inc = (scan_cnt == 16'hFFFF) ? scan_cnt : scan_cnt + 16'd1;

   assign IM_A  = pc;
   assign STATE = state;

   // Scan state machine and program counter
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= S_IDLE;
         pc    <= RESET_PC;
      end else begin
         case (state)
            S_IDLE: begin
               if (RUN) begin
                  state <= S_FETCH;
                  pc    <= RESET_PC;
               end
            end
            S_FETCH: begin
               if (wdt_hit) begin
                  state <= S_FAULT;
               end else if (redirect) begin
                  pc <= BR_TGT;
               end else if (scan_done) begin
                  pc <= RESET_PC;
                  if (!RUN) begin
                     state <= S_IDLE;
                  end
               end else if (issue) begin
                  pc <= pc + IA_W'(1);
               end
            end
            default: begin
               // FAULT is left only through reset
               state <= S_FAULT;
            end
         endcase
      end
   end

   // Instruction register and its valid flag
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         IR_VALID <= 1'b0;
         IR_OP    <= '0;
         IR_ARG   <= '0;
         IR_PC    <= '0;
      end else begin
         if (issue) begin
            IR_VALID <= 1'b1;
            IR_OP    <= im_op;
            IR_ARG   <= im_arg;
            IR_PC    <= pc;
         end else if (!in_fetch || wdt_hit || redirect || scan_done || IR_READY) begin
            // Flush, fault, idle, or the held word was consumed
            IR_VALID <= 1'b0;
         end
      end
   end

   // Scan timing, end-of-scan pulse and sticky watchdog flag
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         scan_cnt  <= 16'd0;
         SCAN_TIME <= 16'd0;
         SCAN_END  <= 1'b0;
         WDT_FAULT <= 1'b0;
      end else begin
         SCAN_END <= scan_done;
         if (scan_done) begin
            SCAN_TIME <= cnt_inc;
            scan_cnt  <= 16'd0;
         end else if (in_fetch && !wdt_hit) begin
            scan_cnt <= cnt_inc;
         end
         if (wdt_hit) begin
            WDT_FAULT <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_plc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_plc_fetch_unit
// Brief    : Self-checking bench for plc_fetch_unit: directed scan scenarios
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef IA_JMP
`define IA_JMP 8'h30
`endif

module tb_plc_fetch_unit;

   localparam logic [7:0] OP_LDI = 8'h01;
   localparam logic [7:0] OP_ADD = 8'h02;
   localparam logic [7:0] OP_JMP = `IA_JMP;
   localparam int         WDT    = 8;

   localparam int ST_IDLE  = 0;
   localparam int ST_FETCH = 1;
   localparam int ST_FAULT = 2;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        RUN = 1'b0;
   logic        IR_READY = 1'b0;
   logic        BR_TAKE = 1'b0;
   logic [15:0] BR_TGT = 16'h0000;
   logic [15:0] IM_A;
   logic [23:0] IM_DQ;
   logic        IR_VALID;
   logic [7:0]  IR_OP;
   logic [15:0] IR_ARG;
   logic [15:0] IR_PC;
   logic        SCAN_END;
   logic [15:0] SCAN_TIME;
   logic        WDT_FAULT;
   logic [1:0]  STATE;

   logic [23:0] mem [0:255];

   int tests = 0;
   int fails = 0;

   // Behavioural model state
   int          m_state;
   logic [15:0] m_pc;
   logic        m_valid;
   logic [7:0]  m_op;
   logic [15:0] m_arg;
   logic [15:0] m_irpc;
   logic        m_end;
   logic [15:0] m_time;
   int          m_cnt;
   logic        m_fault;

   plc_fetch_unit #(
      .IA_W      (16),
      .ID_W      (24),
      .OP_W      (8),
      .RESET_PC  (16'h0000),
      .WDT_LIMIT (16'(WDT))
   ) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .RUN       (RUN),
      .IM_A      (IM_A),
      .IM_DQ     (IM_DQ),
      .IR_VALID  (IR_VALID),
      .IR_READY  (IR_READY),
      .IR_OP     (IR_OP),
      .IR_ARG    (IR_ARG),
      .IR_PC     (IR_PC),
      .BR_TAKE   (BR_TAKE),
      .BR_TGT    (BR_TGT),
      .SCAN_END  (SCAN_END),
      .SCAN_TIME (SCAN_TIME),
      .WDT_FAULT (WDT_FAULT),
      .STATE     (STATE)
   );

   assign IM_DQ = mem[IM_A[7:0]];

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = ST_IDLE;
      m_pc    = 16'h0000;
      m_valid = 1'b0;
      m_op    = 8'h00;
      m_arg   = 16'h0000;
      m_irpc  = 16'h0000;
      m_end   = 1'b0;
      m_time  = 16'h0000;
      m_cnt   = 0;
      m_fault = 1'b0;
   endtask

   // One clock of scan behaviour, expressed from the fetch rules directly
   task automatic model_step();
      logic [23:0] w;
      logic        is_end;
      int          next_cnt;
      w        = mem[m_pc[7:0]];
      is_end   = (w[23:16] == OP_JMP) && (w[15:0] == 16'hFFFF);
      next_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
      m_end    = 1'b0;
      if (m_state == ST_IDLE) begin
         if (RUN) begin
            m_state = ST_FETCH;
            m_pc    = 16'h0000;
         end
      end else if (m_state == ST_FETCH) begin
         if (m_cnt == WDT) begin
            m_state = ST_FAULT;
            m_fault = 1'b1;
            m_valid = 1'b0;
         end else if (BR_TAKE) begin
            m_pc    = BR_TGT;
            m_valid = 1'b0;
            m_cnt   = next_cnt;
         end else if (m_valid && !IR_READY) begin
            m_cnt = next_cnt;
         end else if (is_end) begin
            m_end   = 1'b1;
            m_time  = 16'(m_cnt + 1);
            m_cnt   = 0;
            m_pc    = 16'h0000;
            m_valid = 1'b0;
            if (!RUN) m_state = ST_IDLE;
         end else begin
            m_op    = w[23:16];
            m_arg   = w[15:0];
            m_irpc  = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd1;
            m_cnt   = next_cnt;
         end
      end
   endtask

   task automatic check_all();
      chk("im_a",      IM_A,      m_pc);
      chk("ir_valid",  IR_VALID,  m_valid);
      chk("ir_op",     IR_OP,     m_op);
      chk("ir_arg",    IR_ARG,    m_arg);
      chk("ir_pc",     IR_PC,     m_irpc);
      chk("scan_end",  SCAN_END,  m_end);
      chk("scan_time", SCAN_TIME, m_time);
      chk("wdt_fault", WDT_FAULT, m_fault);
      chk("state",     STATE,     32'(m_state));
   endtask

   task automatic cyc(input logic run, input logic rdy, input logic br, input logic [15:0] tgt);
      RUN      = run;
      IR_READY = rdy;
      BR_TAKE  = br;
      BR_TGT   = tgt;
      model_step();
      @(posedge CLK);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      nRST     = 1'b0;
      RUN      = 1'b0;
      IR_READY = 1'b0;
      BR_TAKE  = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   task automatic load_program();
      for (int i = 0; i < 256; i++) mem[i] = {OP_JMP, 16'hFFFF};
      mem[0]     = {OP_LDI, 16'h0001};
      mem[1]     = {OP_ADD, 16'h0001};
      mem[2]     = {OP_JMP, 16'hFFFF};
      mem[8'h10] = {OP_LDI, 16'h0010};
      mem[8'hFF] = {OP_ADD, 16'h00FF};
   endtask

   initial begin
      model_reset();
      load_program();

      // Reset state and a basic three-word scan
      do_reset();
      chk("rst_state", STATE, 32'd0);
      cyc(1, 1, 0, 0);
      chk("t1_fetch", STATE, 32'd1);
      cyc(1, 1, 0, 0);
      chk("t1_pc0", IR_PC, 32'h0);
      chk("t1_op0", IR_OP, 32'(OP_LDI));
      cyc(1, 1, 0, 0);
      chk("t1_pc1", IR_PC, 32'h1);
      cyc(1, 1, 0, 0);
      chk("t1_end", SCAN_END, 32'd1);
      chk("t1_time", SCAN_TIME, 32'd3);
      cyc(1, 1, 0, 0);
      chk("t1_reissue", IR_PC, 32'h0);
      chk("t1_endpulse", SCAN_END, 32'd0);

      // Decoder stall holds word 0 and PC 1
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0, 0);
         chk("stall_irpc", IR_PC, 32'h0);
         chk("stall_pc", IM_A, 32'h1);
      end
      cyc(1, 1, 0, 0);
      chk("stall_rel", IR_PC, 32'h1);

      // Redirect while a word is valid, then PC wrap at all-ones
      do_reset();
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      chk("br_pre_valid", IR_VALID, 32'd1);
      cyc(1, 0, 1, 16'h0010);
      chk("br_flush", IR_VALID, 32'd0);
      cyc(1, 1, 0, 0);
      chk("br_irpc", IR_PC, 32'h10);
      cyc(1, 1, 0, 0);
      chk("br_time", SCAN_TIME, 32'd4);
      cyc(1, 1, 1, 16'hFFFF);
      cyc(1, 1, 0, 0);
      chk("wrap_irpc", IR_PC, 32'hFFFF);
      chk("wrap_pc", IM_A, 32'h0);

      // RUN dropped mid-scan: scan completes then IDLE
      do_reset();
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk("stop_irpc1", IR_PC, 32'h1);
      chk("stop_still", STATE, 32'd1);
      cyc(0, 1, 0, 0);
      chk("stop_end", SCAN_END, 32'd1);
      chk("stop_idle", STATE, 32'd0);
      chk("stop_valid", IR_VALID, 32'd0);
      cyc(0, 1, 0, 0);
      chk("stop_hold", STATE, 32'd0);

      // Watchdog on a program with no end-of-scan word
      for (int i = 2; i < 16; i++) mem[i] = {OP_JMP, 16'h0000};
      do_reset();
      cyc(1, 1, 0, 0);
      for (int i = 0; i < WDT; i++) cyc(1, 1, 0, 0);
      chk("wdt_pre", WDT_FAULT, 32'd0);
      cyc(1, 1, 0, 0);
      chk("wdt_state", STATE, 32'd2);
      chk("wdt_flag", WDT_FAULT, 32'd1);
      for (int i = 0; i < 3; i++) cyc(i[0], 1, 1, 16'h0010);
      chk("wdt_sticky", STATE, 32'd2);
      do_reset();
      chk("wdt_clear", WDT_FAULT, 32'd0);

      // Asynchronous reset in the middle of a stall
      load_program();
      do_reset();
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("async_pre", IR_VALID, 32'd1);
      #3;
      nRST = 1'b0;
      #1;
      chk("async_valid", IR_VALID, 32'd0);
      chk("async_state", STATE, 32'd0);
      chk("async_pc", IM_A, 32'h0);
      chk("async_op", IR_OP, 32'h0);
      chk("async_arg", IR_ARG, 32'h0);
      model_reset();
      @(posedge CLK);
      #1;
      nRST = 1'b1;

      // Randomized program and handshake traffic
      for (int i = 0; i < 256; i++) begin
         int k;
         k = int'($urandom_range(0, 5));
         if (k < 2)      mem[i] = {OP_LDI, 16'($urandom)};
         else if (k < 4) mem[i] = {OP_ADD, 16'($urandom)};
         else            mem[i] = {OP_JMP, ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom)};
      end
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         if (m_state == ST_FAULT && $urandom_range(0, 3) == 0) begin
            do_reset();
         end else begin
            cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) == 0), 16'($urandom_range(0, 255)));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
